mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory interface for the Y86 core.
- Accepts one memory-stage request per transaction: icode, valA, valE, valP.
- Decodes whether the request is a read or a write, then drives a byte-wide request/acknowledge bus to the memory responder, one byte per beat.
- Assembles 64-bit little-endian loads into valM and reports completion or error back to the core.

Parameters:
- MEM_SIZE, 512, number of addressable bytes behind the bus.
- ACK_TIMEOUT, 16, maximum cycles a beat may wait for bus_ack before the transaction aborts with error.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block is idle and can accept a request.
- icode  in  4  instruction code of the request.
- valA  in  64  read address (9, B) or store data (4, A).
- valE  in  64  address for 4, 5, 8, A.
- valP  in  64  store data for call (8).
- resp_valid  out  1  one-cycle completion pulse.
- valM  out  64  load result, valid with resp_valid.
- error  out  1  address fault or timeout, valid with resp_valid.
- bus_req  out  1  byte beat request.
- bus_we  out  1  1 = write beat, 0 = read beat.
- bus_addr  out  64  byte address of the current beat.
- bus_wdata  out  8  write byte.
- bus_ack  in  1  responder completes the current beat this cycle.
- bus_rdata  in  8  read byte, sampled when bus_ack=1 and bus_we=0.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset state:
  - State IDLE; beat counter 0; timeout counter 0.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - resp_valid=0, valM=0, error=0.
  - rst asserted mid-transaction aborts it: bus_req is low from the next cycle and no resp_valid is issued.
- req_ready = (state==IDLE). It is 1 in the first cycle after rst deasserts.
- Request decode, latched on req_valid && req_ready:
  - icode 5: read at valE.
  - icode 9, B: read at valA.
  - icode 4, A: write valA at valE.
  - icode 8: write valP at valE.
  - Any other icode: no-op.
- Address check: fault if base+7 >= MEM_SIZE, compared as unsigned 64-bit. The check also rejects wrap-around when base+7 overflows.
- States:
  - IDLE: on accept, go to ACCESS if the request is a valid read or write. Go to RESP if it is a no-op (error=0) or faults (error=1); no bus beats are issued in either case.
  - ACCESS:
    - bus_req=1, bus_we per op, bus_addr=base+cnt.
    - bus_wdata = store_data[8*cnt+7 : 8*cnt], byte 0 is the LSB.
    - These signals hold stable until bus_ack.
    - On bus_ack: a read stores bus_rdata into byte cnt of valM, cnt increments, and the timeout counter clears.
    - The ack with cnt==7 goes to RESP, and bus_req drops in that cycle's successor.
    - Timeout counter increments each cycle without ack. Reaching ACK_TIMEOUT gives error=1 and goes to RESP, abandoning the remaining beats.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- valM and error hold their values until the next accept. valM clears to 0 at accept for every request; writes and no-ops return 0.
- Latency with bus_ack tied to 1: accept in cycle 0, beats in cycles 1–8, resp_valid in cycle 9. No-op or fault: resp_valid in cycle 1.
- req_valid while not ready is ignored; the core holds it.
- bus_ack while bus_req=0 is ignored.

Test Plan:
- Reset, then icode=4, valE=0x10, valA=0x1122334455667788, ack always 1:
  - 8 write beats, addr 0x10..0x17, wdata 0x88,0x77,…,0x11.
  - resp_valid in cycle 9 with error=0.
- Memory model preloaded with the prior write, then icode=5, valE=0x10:
  - valM=0x1122334455667788, error=0.
- icode=B, valA=0x1F9 (505) with MEM_SIZE=512:
  - No bus_req.
  - resp_valid in the next cycle with error=1.
  - valE=0xFFFFFFFFFFFFFFFC also faults (wrap-around).
- icode=8, valE=0x40, valP=0xABCD, ack withheld 3 cycles on every beat:
  - Address and data stay stable while waiting.
  - Bytes 0xCD,0xAB,0,…,0 are written.
  - Total 32 cycles of beats, then resp_valid.
- icode=9 with ack never asserted:
  - Error after 16 stalled cycles on beat 0.
  - resp_valid=1, error=1, then req_ready=1.
- rst pulsed during beat 4 of a read:
  - bus_req=0 and all outputs 0 the next cycle; no resp_valid.
  - A fresh icode=0 request then completes in 1 cycle with error=0, valM=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Y86 data-memory initiator: decodes a memory-stage request, walks eight byte
// beats over a req/ack bus, and assembles little-endian loads into valM.
module mem_access_ctrl #(
  parameter int MEM_SIZE    = 512,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        resp_valid,
  output logic [63:0] valM,
  output logic        error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t       r_state, w_state_next;
  logic [2:0]   r_cnt;
  logic [TW-1:0] r_tmo;
  logic         r_we;
  logic [63:0]  r_base;
  logic [63:0]  r_store;
  logic [63:0]  r_valm;
  logic         r_error;

  logic         w_is_rd, w_is_wr, w_fault, w_accept, w_tmo_hit;
  logic [63:0]  w_base, w_store;
  logic [64:0]  w_last_addr;

  always_comb begin
    w_is_rd = 1'b0;
    w_is_wr = 1'b0;
    w_base  = valE;
    w_store = valA;
    case (icode)
      4'h5:       w_is_rd = 1'b1;
      4'h9, 4'hB: begin w_is_rd = 1'b1; w_base = valA; end
      4'h4, 4'hA: w_is_wr = 1'b1;
      4'h8:       begin w_is_wr = 1'b1; w_store = valP; end
      default:    ;
    endcase
  end

  // 65-bit sum so a base near 2^64 that wraps is still caught as a fault
  assign w_last_addr = {1'b0, w_base} + 65'd7;
  assign w_fault     = w_last_addr >= 65'(MEM_SIZE);
  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_tmo_hit   = !bus_ack && (r_tmo == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((w_is_rd || w_is_wr) && !w_fault) w_state_next = S_ACCESS;
          else                                  w_state_next = S_RESP;
        end
      end
      S_ACCESS: begin
        if ((bus_ack && r_cnt == 3'd7) || w_tmo_hit) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_base  <= 64'd0;
      r_store <= 64'd0;
      r_valm  <= 64'd0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_valm  <= 64'd0;
            r_error <= (w_is_rd || w_is_wr) && w_fault;
            r_we    <= w_is_wr;
            r_base  <= w_base;
            r_store <= w_store;
            r_cnt   <= 3'd0;
            r_tmo   <= '0;
          end
        end
        S_ACCESS: begin
          if (bus_ack) begin
            if (!r_we) r_valm[{r_cnt, 3'b000} +: 8] <= bus_rdata;
            r_cnt <= r_cnt + 3'd1;
            r_tmo <= '0;
          end else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are decoded from registered state so they hold until ack
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign bus_req    = (r_state == S_ACCESS);
  assign bus_we     = bus_req && r_we;
  assign bus_addr   = bus_req ? (r_base + {61'd0, r_cnt}) : 64'd0;
  assign bus_wdata  = bus_we ? r_store[{r_cnt, 3'b000} +: 8] : 8'd0;
  assign valM       = r_valm;
  assign error      = r_error;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a reference model predicts responses and
// bus beats, a responder model serves the bus, a monitor checks each response.
module tb_mem_access_ctrl;
  localparam int MEM_SIZE    = 512;
  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        resp_valid;
  logic [63:0] valM;
  logic        error;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  mem_access_ctrl #(.MEM_SIZE(MEM_SIZE), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .icode(icode), .valA(valA), .valE(valE), .valP(valP),
    .resp_valid(resp_valid), .valM(valM), .error(error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] valm;
    logic        err;
    int          lat;
    int          t_acc;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } beat_t;

  resp_t sb[$];
  beat_t bq[$];

  logic [7:0] bench_mem [MEM_SIZE];
  logic [7:0] ref_mem   [MEM_SIZE];

  int ack_delay = 0;
  bit ack_never = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: acks after ack_delay waiting cycles, checks each beat against the model
  int          wait_cnt = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [63:0] prev_addr = 64'd0;
  logic [7:0]  prev_wd = 8'd0;
  always @(negedge clk) begin
    beat_t b;
    bus_ack   = 1'b0;
    bus_rdata = 8'd0;
    if (bus_req && prev_req && !prev_ack) begin
      chk("hold_addr", bus_addr, prev_addr);
      chk("hold_we", 64'(bus_we), 64'(prev_we));
      chk("hold_wdata", 64'(bus_wdata), 64'(prev_wd));
    end
    if (!bus_req) begin
      wait_cnt = 0;
    end else if (!ack_never) begin
      if (wait_cnt == ack_delay) begin
        bus_ack  = 1'b1;
        wait_cnt = 0;
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stray_beat: got bus_req at addr %h expected no beat", bus_addr);
        end else begin
          b = bq.pop_front();
          chk("beat_addr", bus_addr, b.addr);
          chk("beat_we", 64'(bus_we), 64'(b.we));
          if (b.we) chk("beat_wdata", 64'(bus_wdata), 64'(b.wdata));
        end
        if (bus_addr < 64'(MEM_SIZE)) begin
          if (bus_we) bench_mem[bus_addr[8:0]] = bus_wdata;
          else        bus_rdata = bench_mem[bus_addr[8:0]];
        end
      end else begin
        wait_cnt++;
      end
    end
    prev_req  = bus_req;
    prev_ack  = bus_ack;
    prev_we   = bus_we;
    prev_addr = bus_addr;
    prev_wd   = bus_wdata;
  end

  // Monitor: pops the scoreboard on every resp_valid
  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    resp_t e;
    if (prev_resp) chk("ready_after_resp", 64'(req_ready), 64'd1);
    prev_resp = resp_valid;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("valM", valM, e.valm);
        chk("error", 64'(error), 64'(e.err));
        chk("latency", 64'(cyc - e.t_acc), 64'(e.lat));
        chk("beats_left", 64'(bq.size()), 64'd0);
      end
    end
  end

  // Reference model: derives the outcome from the request rules directly
  task automatic model(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input int t_acc);
    bit rd = 0, wr = 0, fault;
    logic [63:0] base = e, store = a;
    resp_t r;
    case (ic)
      4'h5:       rd = 1;
      4'h9, 4'hB: begin rd = 1; base = a; end
      4'h4, 4'hA: wr = 1;
      4'h8:       begin wr = 1; store = p; end
      default:    ;
    endcase
    fault  = (rd || wr) && (base > 64'(MEM_SIZE - 8));
    r.valm = 64'd0;
    r.err  = fault;
    r.lat  = 1;
    r.t_acc = t_acc;
    if ((rd || wr) && !fault) begin
      if (ack_never) begin
        r.err = 1'b1;
        r.lat = ACK_TIMEOUT + 1;
      end else begin
        r.lat = 8 * (ack_delay + 1) + 1;
        for (int i = 0; i < 8; i++) begin
          bq.push_back('{addr: base + 64'(i), we: wr, wdata: store[8*i +: 8]});
          if (rd) r.valm[8*i +: 8] = ref_mem[int'(base) + i];
          else    ref_mem[int'(base) + i] = store[8*i +: 8];
        end
      end
    end
    sb.push_back(r);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got req_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p);
    wait_ready();
    model(ic, a, e, p, cyc);
    icode = ic; valA = a; valE = e; valP = p;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_wait: got no resp_valid expected one within 300 cycles");
      sb.delete();
      bq.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return 64'($urandom_range(0, 520));
    return {$urandom, $urandom};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int mism;
    for (int i = 0; i < MEM_SIZE; i++) begin
      d = 8'($urandom);
      bench_mem[i] = d;
      ref_mem[i]   = d;
    end
    rst = 1'b1; req_valid = 1'b0; icode = 4'h0;
    valA = 64'd0; valE = 64'd0; valP = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Write then read back at 0x10 with ack tied high
    ack_delay = 0;
    issue(4'h4, 64'h1122334455667788, 64'h10, 64'd0);
    wait_resp();
    issue(4'h5, 64'd0, 64'h10, 64'd0);
    wait_resp();
    chk("load_back", valM, 64'h1122334455667788);

    // Address faults, including wrap-around
    issue(4'hB, 64'h1F9, 64'd0, 64'd0);
    wait_resp();
    issue(4'h5, 64'd0, 64'hFFFFFFFFFFFFFFFC, 64'd0);
    wait_resp();

    // call store with ack withheld three cycles per beat
    ack_delay = 3;
    issue(4'h8, 64'd0, 64'h40, 64'hABCD);
    wait_resp();
    chk("call_mem", {bench_mem[16'h47], bench_mem[16'h46], bench_mem[16'h45], bench_mem[16'h44],
                     bench_mem[16'h43], bench_mem[16'h42], bench_mem[16'h41], bench_mem[16'h40]},
        64'hABCD);

    // Responder never acks: timeout on beat 0
    ack_delay = 0;
    ack_never = 1'b1;
    issue(4'h9, 64'h100, 64'd0, 64'd0);
    wait_resp();
    ack_never = 1'b0;

    // Reset during beat 4 of a read: five beats acked, no response
    wait_ready();
    for (int i = 0; i < 5; i++) bq.push_back('{addr: 64'h80 + 64'(i), we: 1'b0, wdata: 8'd0});
    icode = 4'h5; valE = 64'h80; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bus_req", 64'(bus_req), 64'd0);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_valM", valM, 64'd0);
    chk("abort_error", 64'(error), 64'd0);
    chk("abort_beats", 64'(bq.size()), 64'd0);
    bq.delete();
    rst = 1'b0;
    @(negedge clk);
    issue(4'h0, 64'd0, 64'd0, 64'd0);
    wait_resp();

    // Randomized mix
    for (int t = 0; t < 40; t++) begin
      ack_delay = $urandom_range(0, 3);
      issue(4'($urandom_range(0, 15)), rand_addr(), rand_addr(), {$urandom, $urandom});
      wait_resp();
    end

    mism = 0;
    for (int i = 0; i < MEM_SIZE; i++) if (bench_mem[i] !== ref_mem[i]) mism++;
    chk("mem_final_mismatches", 64'(mism), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
